// File: rtl/dm_pkg.sv
// Shared encodings and byte-lane helpers for the byte-addressable data memory.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} dm_state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lane;
      SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lane[0];
      SZ_WORD: is_misaligned = |lane;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Load-side lane extraction/extension and store-side lane replication.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] wrep_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: ldata_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: ldata_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
      default: ldata_o = word_i;
    endcase
    // Replicate so the lane mask alone picks which bytes land.
    case (size_i)
      SZ_BYTE: wrep_o = {4{wdata_i[7:0]}};
      SZ_HALF: wrep_o = {2{wdata_i[15:0]}};
      default: wrep_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dm_bytelane.sv
// Byte/half/word data memory with registered loads, misalign flag and post-reset clear sweep.
module dm_bytelane
  import dm_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic              misalign_o,
  output logic              busy_o
);

  localparam int IW = $clog2(DEPTH);
  localparam dm_state_e RST_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  logic [31:0]       mem_q [DEPTH];
  dm_state_e         state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [31:0]       rdata_q;
  logic              rvalid_q, misalign_q;

  logic [ADDR_W-3:0] widx;
  logic              in_range, mis, accept, do_wr, do_rd;
  logic [3:0]        mask;
  logic [31:0]       rd_word, ldata, wrep;

  always_comb begin
    widx     = addr_i[ADDR_W-1:2];
    in_range = 32'(widx) < 32'(DEPTH);
    mis      = is_misaligned(size_i, addr_i[1:0]);
    mask     = lane_mask(size_i, addr_i[1:0]);
    accept   = req_i && (state_q == ST_IDLE);
    do_wr    = accept && we_i && !mis && in_range;
    do_rd    = accept && !we_i && !mis;
    rd_word  = in_range ? mem_q[widx[IW-1:0]] : 32'h0;
  end

  dm_lane_align u_align (
    .word_i     (rd_word),
    .lane_i     (addr_i[1:0]),
    .size_i     (size_i),
    .sign_ext_i (sign_ext_i),
    .wdata_i    (wdata_i),
    .ldata_o    (ldata),
    .wrep_o     (wrep)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_CLEAR) begin
      if (idx_q == IW'(DEPTH - 1)) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= RST_ST;
      idx_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rvalid_q   <= do_rd;
      misalign_q <= accept && mis;
      if (do_rd) rdata_q <= ldata;
    end
  end

  // Array has no reset so contents survive reset when the sweep is disabled.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      mem_q[idx_q] <= '0;
    end else if (do_wr) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) mem_q[widx[IW-1:0]][b*8 +: 8] <= wrep[b*8 +: 8];
    end
  end

  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign misalign_o = misalign_q;
  assign busy_o     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dm_bytelane.sv
// Directed bench for dm_bytelane with DEPTH=16 and the clear sweep enabled.
module tb_dm_bytelane;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, misalign, busy;

  int checks = 0;
  int errors = 0;
  int n;
  logic seen_rv;

  always #5 clk = ~clk;

  dm_bytelane #(.DEPTH(16), .ADDR_W(10), .CLEAR_ON_RESET(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .size_i(size),
    .sign_ext_i(sign_ext), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .rvalid_o(rvalid), .misalign_o(misalign), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic se,
                        input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = se; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk); @(posedge clk); #1;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic se,
                          input logic [9:0] a, input logic [31:0] exp);
    access(1'b0, sz, se, a, 32'h0);
    check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
    check(tag, rdata, exp);
  endtask

  // Counts edges until busy drops, holding a load request the whole time.
  task automatic sweep_count(output int cnt, output logic rv);
    cnt = 0; rv = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 10'h010;
    rst_n = 1'b1;
    while (busy && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      if (rvalid || misalign) rv = 1'b1;
    end
    req = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);

    sweep_count(n, seen_rv);
    check("sweep_len", n, 32'd16);
    check("sweep_no_rvalid", {31'b0, seen_rv}, 32'd0);
    idle();
    check("post_sweep_rvalid", {31'b0, rvalid}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      access(1'b0, 2'b10, 1'b0, 10'(i * 4), 32'h0);
      check($sformatf("clr_w%0d", i), rdata, 32'h0);
    end

    access(1'b1, 2'b10, 1'b0, 10'h010, 32'h8899AABB);
    check("st_no_rvalid", {31'b0, rvalid}, 32'd0);
    load_chk("lb_s", 2'b00, 1'b1, 10'h011, 32'hFFFFFFAA);
    load_chk("lb_z", 2'b00, 1'b0, 10'h011, 32'h000000AA);
    access(1'b1, 2'b01, 1'b0, 10'h012, 32'h00001234);
    load_chk("lw_merge", 2'b10, 1'b0, 10'h010, 32'h1234AABB);
    load_chk("lh_s_pos", 2'b01, 1'b1, 10'h012, 32'h00001234);
    load_chk("lh_s_neg", 2'b01, 1'b1, 10'h010, 32'hFFFFAABB);
    load_chk("lb_z3", 2'b00, 1'b0, 10'h013, 32'h00000012);

    access(1'b0, 2'b01, 1'b1, 10'h011, 32'h0);
    check("mis_lh_flag", {31'b0, misalign}, 32'd1);
    check("mis_lh_rvalid", {31'b0, rvalid}, 32'd0);
    check("mis_lh_rdata", rdata, 32'h00000012);
    idle();
    check("mis_pulse_end", {31'b0, misalign}, 32'd0);
    access(1'b1, 2'b10, 1'b0, 10'h012, 32'hDEADBEEF);
    check("mis_sw_flag", {31'b0, misalign}, 32'd1);
    access(1'b0, 2'b11, 1'b0, 10'h010, 32'h0);
    check("mis_sz11_flag", {31'b0, misalign}, 32'd1);
    check("mis_sz11_rdata", rdata, 32'h00000012);
    load_chk("mis_mem_kept", 2'b10, 1'b0, 10'h010, 32'h1234AABB);

    access(1'b1, 2'b10, 1'b0, 10'h3FC, 32'hCAFEF00D);
    load_chk("oor_load", 2'b10, 1'b0, 10'h3FC, 32'h0);
    load_chk("oor_no_alias", 2'b10, 1'b0, 10'h03C, 32'h0);

    access(1'b1, 2'b00, 1'b0, 10'h021, 32'h0000005A);
    load_chk("sb_then_lw", 2'b10, 1'b0, 10'h020, 32'h00005A00);

    rst_n = 1'b0; #1;
    check("async_rdata", rdata, 32'h0);
    check("async_rvalid", {31'b0, rvalid}, 32'd0);
    check("async_busy", {31'b0, busy}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0; #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd1);
    sweep_count(n, seen_rv);
    check("resweep_len", n, 32'd16);
    check("resweep_no_rvalid", {31'b0, seen_rv}, 32'd0);
    load_chk("resweep_cleared", 2'b10, 1'b0, 10'h010, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
